// File: rtl/axi_host_pkg.sv
// Shared encodings for the host command queue.
// Host-bus command, response status and sequencer state types.
package axi_host_pkg;

  localparam logic [1:0] RW_IDLE  = 2'b00;
  localparam logic [1:0] RW_WRITE = 2'b01;
  localparam logic [1:0] RW_READ  = 2'b10;

  localparam logic [1:0] STATUS_OK      = 2'b00;
  localparam logic [1:0] STATUS_ERROR   = 2'b01;
  localparam logic [1:0] STATUS_INVALID = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CLEAR,
    ST_DRAIN,
    ST_RESP
  } state_t;

  // A rejected command outranks a bus error.
  function automatic logic [1:0] rsp_status(
    input logic inv,
    input logic err
  );
    logic [1:0] s;
    s = STATUS_OK;
    if (inv)      s = STATUS_INVALID;
    else if (err) s = STATUS_ERROR;
    return s;
  endfunction

endpackage

// File: rtl/axi_host_req_fifo.sv
// Request FIFO for the host command queue.
// Synchronous, first-word-fall-through head, registered count.
module axi_host_req_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy tracking; pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count
             + {{AW{1'b0}}, do_push}
             - {{AW{1'b0}}, do_pop};
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/axi_host_cmd_queue.sv
// Host request queue sequencing one op at a time onto the host bus.
// Optional AXI_HOST_CMD_STATS_EN adds saturating OK/error counters.
module axi_host_cmd_queue
  import axi_host_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_write,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [DATA_WIDTH-1:0] i_req_wdata,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic                  o_rsp_write,
  output logic [DATA_WIDTH-1:0] o_rsp_rdata,
  output logic [1:0]            o_rsp_status,
  output logic [ADDR_WIDTH-1:0] o_m_addr,
  output logic [DATA_WIDTH-1:0] o_m_wdata,
  output logic [1:0]            o_m_rw,
  input  logic                  i_m_wait,
  input  logic                  i_m_done,
  output logic                  o_m_clear_done,
  input  logic [DATA_WIDTH-1:0] i_m_rdata,
  input  logic                  i_m_invalid,
  input  logic                  i_m_error
`ifdef AXI_HOST_CMD_STATS_EN
  ,
  output logic [15:0]           o_stat_ok,
  output logic [15:0]           o_stat_err
`endif
);

  localparam int FIFO_W = 1 + ADDR_WIDTH + DATA_WIDTH;

  state_t state;
  state_t state_nxt;

  logic [FIFO_W-1:0]     fifo_head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_pop;
  logic                  m_hit;
  logic                  m_wait_unused;

  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic [DATA_WIDTH-1:0] res_rdata;
  logic [1:0]            res_status;

  // The master's busy flag carries no extra information once
  // done/invalid are observed.
  assign m_wait_unused = i_m_wait;

  assign m_hit       = i_m_done || i_m_invalid;
  assign o_req_ready = !fifo_full;
  assign o_m_addr    = cmd_addr;
  assign o_m_wdata   = cmd_wdata;

  axi_host_req_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (i_clk),
    .rst       (i_rst),
    .push      (i_req_valid),
    .push_data ({i_req_write, i_req_addr, i_req_wdata}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Sequencer state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next state, FIFO pop and host-bus strobes.
  always_comb begin
    state_nxt      = state;
    fifo_pop       = 1'b0;
    o_m_rw         = RW_IDLE;
    o_m_clear_done = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!fifo_empty && !o_rsp_valid && !i_m_done) begin
          fifo_pop  = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        o_m_rw = cmd_write ? RW_WRITE : RW_READ;
        if (m_hit) state_nxt = ST_CLEAR;
      end
      ST_CLEAR: begin
        o_m_clear_done = 1'b1;
        state_nxt      = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!m_hit) state_nxt = ST_RESP;
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Command registers loaded from the FIFO head on pop.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cmd_write <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
    end else if (fifo_pop) begin
      {cmd_write, cmd_addr, cmd_wdata} <= fifo_head;
    end
  end

  // Capture completion data while the command is still on the bus.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      res_rdata  <= '0;
      res_status <= STATUS_OK;
    end else if (state == ST_ISSUE && m_hit) begin
      res_rdata  <= cmd_write ? '0 : i_m_rdata;
      res_status <= rsp_status(i_m_invalid, i_m_error);
    end
  end

  // Response register: filled in RESP, emptied on handshake.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rsp_valid  <= 1'b0;
      o_rsp_write  <= 1'b0;
      o_rsp_rdata  <= '0;
      o_rsp_status <= STATUS_OK;
    end else if (state == ST_RESP) begin
      o_rsp_valid  <= 1'b1;
      o_rsp_write  <= cmd_write;
      o_rsp_rdata  <= res_rdata;
      o_rsp_status <= res_status;
    end else if (o_rsp_valid && i_rsp_ready) begin
      o_rsp_valid  <= 1'b0;
      o_rsp_write  <= 1'b0;
      o_rsp_rdata  <= '0;
      o_rsp_status <= STATUS_OK;
    end
  end

`ifdef AXI_HOST_CMD_STATS_EN
  logic resp_enter;
  assign resp_enter = (state == ST_DRAIN) && (state_nxt == ST_RESP);

  // Saturating outcome counters, bumped as RESP is entered.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_stat_ok  <= '0;
      o_stat_err <= '0;
    end else if (resp_enter) begin
      if (res_status == STATUS_OK) begin
        if (o_stat_ok != 16'hFFFF) o_stat_ok <= o_stat_ok + 16'd1;
      end else begin
        if (o_stat_err != 16'hFFFF) o_stat_err <= o_stat_err + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_axi_host_cmd_queue.sv
// Directed bench for axi_host_cmd_queue with a small host-bus slave.
// Stats checks compile in when AXI_HOST_CMD_STATS_EN is defined.
module tb_axi_host_cmd_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_status;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [1:0]  m_rw;
  logic        m_wait;
  logic        m_done;
  logic        m_clear;
  logic [31:0] m_rdata;
  logic        m_inv;
  logic        m_err;
`ifdef AXI_HOST_CMD_STATS_EN
  logic [15:0] stat_ok;
  logic [15:0] stat_err;
`endif

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  axi_host_cmd_queue #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .FIFO_DEPTH (4)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_req_valid    (req_valid),
    .o_req_ready    (req_ready),
    .i_req_write    (req_write),
    .i_req_addr     (req_addr),
    .i_req_wdata    (req_wdata),
    .o_rsp_valid    (rsp_valid),
    .i_rsp_ready    (rsp_ready),
    .o_rsp_write    (rsp_write),
    .o_rsp_rdata    (rsp_rdata),
    .o_rsp_status   (rsp_status),
    .o_m_addr       (m_addr),
    .o_m_wdata      (m_wdata),
    .o_m_rw         (m_rw),
    .i_m_wait       (m_wait),
    .i_m_done       (m_done),
    .o_m_clear_done (m_clear),
    .i_m_rdata      (m_rdata),
    .i_m_invalid    (m_inv),
    .i_m_error      (m_err)
`ifdef AXI_HOST_CMD_STATS_EN
    ,
    .o_stat_ok      (stat_ok),
    .o_stat_err     (stat_err)
`endif
  );

  // Slave model: mode 0 OKAY, 1 SLVERR, 2 invalid pulse.
  typedef struct {
    logic [1:0]  rw;
    logic [31:0] addr;
    logic [31:0] wdata;
  } op_t;

  op_t         op_log [$];
  logic [31:0] rd_q [$];
  int          lat_cfg  = 2;
  int          mode_cfg = 0;
  int          clr_cnt  = 0;
  int          hold_err = 0;
  int          cnt      = 0;
  bit          busy     = 0;
  logic [1:0]  cur_rw;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;

  // Slave drives its outputs on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      m_wait  = 1'b0;
      m_done  = 1'b0;
      m_inv   = 1'b0;
      m_err   = 1'b0;
      m_rdata = '0;
      busy    = 0;
    end else begin
      m_inv = 1'b0;
      if (m_clear) begin
        clr_cnt++;
        m_done = 1'b0;
        m_err  = 1'b0;
      end
      if (busy) begin
        if (m_rw !== cur_rw || m_addr !== cur_addr ||
            m_wdata !== cur_wdata)
          hold_err++;
        if (cnt == 0) begin
          busy   = 0;
          m_wait = 1'b0;
          if (mode_cfg == 2) m_inv = 1'b1;
          else begin
            m_done = 1'b1;
            m_err  = (mode_cfg == 1);
          end
        end else begin
          cnt--;
        end
      end else if (!m_done && !m_clear && m_rw != 2'b00) begin
        busy      = 1;
        cnt       = lat_cfg;
        m_wait    = 1'b1;
        cur_rw    = m_rw;
        cur_addr  = m_addr;
        cur_wdata = m_wdata;
        op_log.push_back('{m_rw, m_addr, m_wdata});
        if (m_rw == 2'b10)
          m_rdata = (rd_q.size() > 0) ? rd_q.pop_front() : '0;
        else
          m_rdata = 32'h5555_5555;
      end
    end
  end

  task automatic push(input logic w, input logic [31:0] a,
                      input logic [31:0] d);
    int n = 0;
    while (!req_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!req_ready) begin
      vectors++; errors++;
      $display("FAIL push_timeout: req_ready=%0b required 1",
               req_ready);
    end
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic get_rsp(output logic w, output logic [31:0] d,
                         output logic [1:0] s);
    int n = 0;
    while (!rsp_valid && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (!rsp_valid) begin
      vectors++; errors++;
      $display("FAIL rsp_timeout: rsp_valid=%0b required 1",
               rsp_valid);
    end
    w = rsp_write;
    d = rsp_rdata;
    s = rsp_status;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (m_rw !== 2'b00 || rsp_valid !== 1'b0 || m_clear !== 1'b0) begin
      errors++;
      $display("FAIL reset_outs: rw=%b rv=%b clr=%b required 00/0/0",
               m_rw, rsp_valid, m_clear);
    end
    vectors++;
    if (m_addr !== 32'h0 || m_wdata !== 32'h0 || rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: addr=%h wd=%h rd=%h required 0",
               m_addr, m_wdata, rsp_rdata);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (req_ready !== 1'b1 || m_rw !== 2'b00) begin
      errors++;
      $display("FAIL reset_idle: ready=%b rw=%b required 1/00",
               req_ready, m_rw);
    end
  endtask

  task automatic test_error();
    logic w; logic [31:0] d; logic [1:0] s;
    lat_cfg = 1;
    mode_cfg = 0;
    push(1'b1, 32'h6000_0000, 32'h0000_0001);
    get_rsp(w, d, s);
    mode_cfg = 1;
    push(1'b1, 32'h6000_0004, 32'h0BAD_0BAD);
    get_rsp(w, d, s);
    vectors++;
    if (s !== 2'b01 || w !== 1'b1) begin
      errors++;
      $display("FAIL slverr_status: st=%b w=%b required 01/1", s, w);
    end
`ifdef AXI_HOST_CMD_STATS_EN
    vectors++;
    if (stat_ok !== 16'd1 || stat_err !== 16'd1) begin
      errors++;
      $display("FAIL stats_1each: ok=%0d err=%0d required 1/1",
               stat_ok, stat_err);
    end
`endif
    mode_cfg = 2;
    push(1'b0, 32'h6000_0008, 32'h0);
    get_rsp(w, d, s);
    vectors++;
    if (s !== 2'b10 || w !== 1'b0) begin
      errors++;
      $display("FAIL invalid_status: st=%b w=%b required 10/0", s, w);
    end
`ifdef AXI_HOST_CMD_STATS_EN
    vectors++;
    if (stat_ok !== 16'd1 || stat_err !== 16'd2) begin
      errors++;
      $display("FAIL stats_inv: ok=%0d err=%0d required 1/2",
               stat_ok, stat_err);
    end
`endif
    mode_cfg = 0;
  endtask

  task automatic test_write();
    logic w; logic [31:0] d; logic [1:0] s;
    clr_cnt  = 0;
    hold_err = 0;
    op_log.delete();
    lat_cfg = 3;
    push(1'b1, 32'h1000_0000, 32'hCAFE_BABE);
    get_rsp(w, d, s);
    vectors++;
    if (w !== 1'b1 || s !== 2'b00 || d !== 32'h0) begin
      errors++;
      $display("FAIL write_rsp: w=%b st=%b rd=%h required 1/00/0",
               w, s, d);
    end
    vectors++;
    if (op_log.size() != 1 || op_log[0].rw !== 2'b01 ||
        op_log[0].addr !== 32'h1000_0000 ||
        op_log[0].wdata !== 32'hCAFE_BABE) begin
      errors++;
      $display("FAIL write_bus: ops=%0d rw=%b a=%h d=%h required 1/01",
               op_log.size(), op_log[0].rw, op_log[0].addr,
               op_log[0].wdata);
    end
    vectors++;
    if (clr_cnt != 1 || hold_err != 0) begin
      errors++;
      $display("FAIL write_clear: clr=%0d hold=%0d required 1/0",
               clr_cnt, hold_err);
    end
  endtask

  task automatic test_read();
    logic w; logic [31:0] d; logic [1:0] s;
    op_log.delete();
    lat_cfg = 2;
    rd_q.push_back(32'hDEAD_BEEF);
    push(1'b0, 32'h2000_0000, 32'h0);
    get_rsp(w, d, s);
    vectors++;
    if (w !== 1'b0 || s !== 2'b00 || d !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL read_rsp: w=%b st=%b rd=%h required 0/00/deadbeef",
               w, s, d);
    end
    vectors++;
    if (m_rw !== 2'b00 || op_log.size() != 1 ||
        op_log[0].rw !== 2'b10) begin
      errors++;
      $display("FAIL read_bus: rw=%b ops=%0d required 00/1",
               m_rw, op_log.size());
    end
  endtask

  task automatic test_back_to_back();
    logic        w; logic [31:0] d; logic [1:0] s;
    logic        sw; logic [31:0] sd; logic [1:0] ss;
    logic        ew [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] ed [5] = '{32'h0, 32'hA0A0_0001, 32'h0,
                            32'hA0A0_0003, 32'h0};
    logic [31:0] ea [5] = '{32'h4000_0000, 32'h4000_0004,
                            32'h4000_0008, 32'h4000_000C,
                            32'h4000_0010};
    int chg = 0;
    int iss = 0;
    int n = 0;
    op_log.delete();
    hold_err = 0;
    lat_cfg = 1;
    rd_q.push_back(32'hA0A0_0001);
    rd_q.push_back(32'hA0A0_0003);
    push(1'b1, 32'h4000_0000, 32'h1111_1111);
    while (!rsp_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    push(1'b0, 32'h4000_0004, 32'h0);
    sw = rsp_write; sd = rsp_rdata; ss = rsp_status;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b1 || rsp_write !== sw ||
          rsp_rdata !== sd || rsp_status !== ss)
        chg++;
      if (m_rw !== 2'b00) iss++;
    end
    vectors++;
    if (chg != 0 || sw !== 1'b1) begin
      errors++;
      $display("FAIL hold_stable: changes=%0d w=%b required 0/1",
               chg, sw);
    end
    vectors++;
    if (iss != 0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL hold_noissue: issued=%0d ready=%b required 0/1",
               iss, req_ready);
    end
    push(1'b1, 32'h4000_0008, 32'h2222_2222);
    push(1'b0, 32'h4000_000C, 32'h0);
    push(1'b1, 32'h4000_0010, 32'h3333_3333);
    vectors++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL fifo_full: ready=%b required 0", req_ready);
    end
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h4000_0014;
    req_wdata = 32'h4444_4444;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL fifth_blocked: ready=%b required 0", req_ready);
    end
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      get_rsp(w, d, s);
      vectors++;
      if (w !== ew[i] || d !== ed[i] || s !== 2'b00) begin
        errors++;
        $display("FAIL order_rsp%0d: w=%b rd=%h st=%b required %b/%h/00",
                 i, w, d, s, ew[i], ed[i]);
      end
    end
    repeat (20) @(posedge clk);
    #1;
    vectors++;
    if (rsp_valid !== 1'b0 || op_log.size() != 5) begin
      errors++;
      $display("FAIL order_count: rv=%b ops=%0d required 0/5",
               rsp_valid, op_log.size());
    end
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (i >= op_log.size() || op_log[i].addr !== ea[i] ||
          op_log[i].rw !== (ew[i] ? 2'b01 : 2'b10)) begin
        errors++;
        $display("FAIL order_bus%0d: a=%h required %h",
                 i, (i < op_log.size()) ? op_log[i].addr : 32'hx, ea[i]);
      end
    end
    vectors++;
    if (hold_err != 0) begin
      errors++;
      $display("FAIL b2b_hold: hold=%0d required 0", hold_err);
    end
  endtask

  task automatic test_reset_mid();
    logic w; logic [31:0] d; logic [1:0] s;
    int n = 0;
    int bad = 0;
    lat_cfg = 20;
    push(1'b1, 32'h5000_0000, 32'h5A5A_5A5A);
    while (m_rw == 2'b00 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    push(1'b1, 32'h5000_0004, 32'h1);
    push(1'b0, 32'h5000_0008, 32'h0);
    push(1'b1, 32'h5000_000C, 32'h2);
    push(1'b0, 32'h5000_0010, 32'h0);
    vectors++;
    if (m_rw !== 2'b01 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL pre_reset: rw=%b ready=%b required 01/0",
               m_rw, req_ready);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (m_rw !== 2'b00 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: rw=%b rv=%b ready=%b required 00/0/1",
               m_rw, rsp_valid, req_ready);
    end
    rst = 1'b0;
    op_log.delete();
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (m_rw !== 2'b00 || rsp_valid !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0 || op_log.size() != 0) begin
      errors++;
      $display("FAIL fifo_dropped: bad=%0d ops=%0d required 0/0",
               bad, op_log.size());
    end
    lat_cfg = 1;
    push(1'b1, 32'h7000_0000, 32'h7777_7777);
    get_rsp(w, d, s);
    vectors++;
    if (w !== 1'b1 || s !== 2'b00 || op_log.size() != 1 ||
        op_log[0].addr !== 32'h7000_0000) begin
      errors++;
      $display("FAIL post_reset_op: w=%b st=%b ops=%0d required 1/00/1",
               w, s, op_log.size());
    end
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_error();
    test_write();
    test_read();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
